spi_master_tx: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) master transmitter.
- Serialises a WIDTH-bit parallel word onto MOSI and generates SCLK and an active-low chip select from the system clock.
- Sends configuration and command words to the ADC/peripheral whose samples the SPI receive datapath captures, so it is the outbound direction of the same link.
- Parallel side uses a valid/ready handshake; the serial side is fully registered.

---
 rtl/spi_master_tx_if.sv | 29 ++
 rtl/spi_master_tx.sv | 152 +++++++++++++++
 tb/tb_spi_master_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | spi_master_tx_if : parallel valid/ready word port of spi_master_tx        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface spi_master_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done
  );
endinterface
`default_nettype wire

// File: rtl/spi_master_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | spi_master_tx : SPI mode-0 master transmitter, registered serial outputs |
// | Option macro SPI_TX_LSB_FIRST_EN reverses bit order (LSB first).          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_master_tx #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  wire logic      clk,
  input  wire logic      reset_b,
  spi_master_tx_if.slave bus,
  output logic           SPI_clk,
  output logic           SPI_cs_b,
  output logic           SPI_Data_out
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'(CS_GAP - 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_SETUP = 3'd1;
  localparam logic [2:0] c_S_HIGH  = 3'd2;
  localparam logic [2:0] c_S_LOW   = 3'd3;
  localparam logic [2:0] c_S_HOLD  = 3'd4;
  localparam logic [2:0] c_S_GAP   = 3'd5;

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [GAP_W-1:0] r_gap;
  logic [WIDTH-1:0] r_shift;
  logic             r_sclk;
  logic             r_cs_b;
  logic             r_mosi;
  logic             r_done;

  logic             w_handshake;
  logic             w_div_last;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_nxt;

  // The shift register rotates so every bit stays live; only the bit
  // adjacent to the output end is ever driven onto MOSI.
`ifdef SPI_TX_LSB_FIRST_EN
  assign w_first_bit = bus.tx_data[0];
  assign w_next_bit  = r_shift[1];
  assign w_shift_nxt = {r_shift[0], r_shift[WIDTH-1:1]};
`else
  assign w_first_bit = bus.tx_data[WIDTH-1];
  assign w_next_bit  = r_shift[WIDTH-2];
  assign w_shift_nxt = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
`endif

  assign w_handshake = bus.tx_valid && (r_state == c_S_IDLE);
  assign w_div_last  = (r_div == c_DIV_LAST);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= c_S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_gap   <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_cs_b  <= 1'b1;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (w_handshake) begin
            r_shift <= bus.tx_data;
            r_mosi  <= w_first_bit;
            r_cs_b  <= 1'b0;
            r_bit   <= '0;
            r_div   <= '0;
            r_state <= c_S_SETUP;
          end
        end
        c_S_SETUP, c_S_LOW: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_sclk  <= 1'b1;
            r_state <= c_S_HIGH;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_S_HIGH: begin
          if (w_div_last) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            if (r_bit == c_BIT_LAST) begin
              r_state <= c_S_HOLD;
            end else begin
              r_shift <= w_shift_nxt;
              r_mosi  <= w_next_bit;
              r_bit   <= r_bit + 1'b1;
              r_state <= c_S_LOW;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_S_HOLD: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_cs_b  <= 1'b1;
            r_done  <= 1'b1;
            r_gap   <= '0;
            r_state <= c_S_GAP;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_S_GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_mosi  <= 1'b0;
            r_state <= c_S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= c_S_IDLE;
          r_sclk  <= 1'b0;
          r_cs_b  <= 1'b1;
          r_mosi  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_ready  = (r_state == c_S_IDLE);
  assign bus.tx_done   = r_done;
  assign SPI_clk       = r_sclk;
  assign SPI_cs_b      = r_cs_b;
  assign SPI_Data_out  = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_spi_master_tx : directed bench for spi_master_tx (16/4/2 and 2/1/1)   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  spi_master_tx_if #(.WIDTH(16)) bus0 ();
  spi_master_tx_if #(.WIDTH(2))  bus1 ();

  logic sclk0, cs0, mosi0;
  logic sclk1, cs1, mosi1;

  spi_master_tx #(.WIDTH(16), .CLK_DIV(4), .CS_GAP(2)) dut0 (
    .clk(clk), .reset_b(reset_b), .bus(bus0.slave),
    .SPI_clk(sclk0), .SPI_cs_b(cs0), .SPI_Data_out(mosi0)
  );

  spi_master_tx #(.WIDTH(2), .CLK_DIV(1), .CS_GAP(1)) dut1 (
    .clk(clk), .reset_b(reset_b), .bus(bus1.slave),
    .SPI_clk(sclk1), .SPI_cs_b(cs1), .SPI_Data_out(mosi1)
  );

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_errors = 0;

  int          m_falls, m_cs_low, m_dones, m_done_bad, m_ready_bad, m_mosi_bad, m_gap;
  int          m_rises [2];
  logic [15:0] m_bits  [2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Observes dut0 on every falling clk edge; also drives its parallel port.
  task automatic monitor(input int ncyc, input int release_falls, input logic [15:0] data2,
                         input int inject_at, input logic [15:0] inj);
    logic p_cs, p_sclk, p_mosi;
    int   fi;
    p_cs = 1'b1; p_sclk = 1'b0; p_mosi = mosi0;
    m_falls = 0; m_cs_low = 0; m_dones = 0; m_done_bad = 0;
    m_ready_bad = 0; m_mosi_bad = 0; m_gap = 0;
    m_rises[0] = 0; m_rises[1] = 0; m_bits[0] = '0; m_bits[1] = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (p_cs && !cs0) begin
        m_falls++;
        bus0.tx_data = data2;
        if (m_falls == release_falls) bus0.tx_valid = 1'b0;
      end
      fi = (m_falls > 1) ? 1 : 0;
      if (!cs0) m_cs_low++;
      if (!cs0 && bus0.tx_ready) m_ready_bad++;
      if (!p_sclk && sclk0) begin
        m_rises[fi]++;
        m_bits[fi] = {m_bits[fi][14:0], mosi0};
      end
      if ((mosi0 != p_mosi) && !cs0 && !(p_sclk && !sclk0) && !(p_cs && !cs0)) m_mosi_bad++;
      if (bus0.tx_done) begin
        m_dones++;
        if (!(cs0 && !p_cs)) m_done_bad++;
      end
      if (m_falls == 1 && cs0) m_gap++;
      if (inject_at >= 0 && c == inject_at) begin
        bus0.tx_valid = 1'b1;
        bus0.tx_data  = inj;
      end else if (inject_at >= 0 && c == inject_at + 1) begin
        bus0.tx_valid = 1'b0;
      end
      p_cs = cs0; p_sclk = sclk0; p_mosi = mosi0;
    end
  endtask

  task automatic run_vec(input logic [15:0] d, input logic [15:0] exp_bits);
    @(negedge clk);
    chk("ready_before_frame", int'(bus0.tx_ready), 1);
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = d;
    monitor(150, 1, ~d, -1, 16'h0000);
    chk("frame_count",     m_falls, 1);
    chk("frame_bits",      int'(m_bits[0]), int'(exp_bits));
    chk("sclk_rises",      m_rises[0], 16);
    chk("cs_low_clks",     m_cs_low, 132);
    chk("done_pulses",     m_dones, 1);
    chk("done_not_at_cs_rise", m_done_bad, 0);
    chk("ready_while_busy", m_ready_bad, 0);
    chk("mosi_off_fall",   m_mosi_bad, 0);
    chk("mosi_idle",       int'(mosi0), 0);
    chk("ready_idle",      int'(bus0.tx_ready), 1);
  endtask

  initial begin
`ifdef SPI_TX_LSB_FIRST_EN
    vecs[0] = '{16'hA5C3, 16'hC3A5};
    vecs[1] = '{16'h0001, 16'h8000};
    vecs[2] = '{16'h8001, 16'h8001};
    vecs[3] = '{16'h00FF, 16'hFF00};
    vecs[4] = '{16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h0000, 16'h0000};
`else
    vecs[0] = '{16'hA5C3, 16'hA5C3};
    vecs[1] = '{16'h0001, 16'h0001};
    vecs[2] = '{16'h8001, 16'h8001};
    vecs[3] = '{16'h00FF, 16'h00FF};
    vecs[4] = '{16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'h0000, 16'h0000};
`endif

    reset_b = 1'b0;
    bus0.tx_valid = 1'b0; bus0.tx_data = '0;
    bus1.tx_valid = 1'b0; bus1.tx_data = '0;
    @(negedge clk);
    chk("rst_cs",    int'(cs0), 1);
    chk("rst_sclk",  int'(sclk0), 0);
    chk("rst_mosi",  int'(mosi0), 0);
    chk("rst_done",  int'(bus0.tx_done), 0);
    chk("rst_ready", int'(bus0.tx_ready), 1);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    chk("post_rst_cs",    int'(cs0), 1);
    chk("post_rst_ready", int'(bus0.tx_ready), 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i].data, vecs[i].exp_bits);

    // Back-to-back: valid held, data swapped once the first frame starts.
    @(negedge clk);
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = 16'h1234;
    monitor(300, 2, 16'hFFFF, -1, 16'h0000);
    chk("b2b_frames",   m_falls, 2);
`ifdef SPI_TX_LSB_FIRST_EN
    chk("b2b_bits0",    int'(m_bits[0]), 32'h2C48);
`else
    chk("b2b_bits0",    int'(m_bits[0]), 32'h1234);
`endif
    chk("b2b_bits1",    int'(m_bits[1]), 32'hFFFF);
    chk("b2b_rises0",   m_rises[0], 16);
    chk("b2b_rises1",   m_rises[1], 16);
    chk("b2b_cs_gap",   m_gap, 3);
    chk("b2b_cs_low",   m_cs_low, 264);
    chk("b2b_dones",    m_dones, 2);
    chk("b2b_ready",    m_ready_bad, 0);

    // Busy ignore: a pulse on tx_valid mid-frame must not queue a frame.
    @(negedge clk);
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = 16'h0000;
    monitor(220, 1, 16'h0000, 40, 16'h0F0F);
    chk("busy_frames", m_falls, 1);
    chk("busy_bits",   int'(m_bits[0]), 0);
    chk("busy_rises",  m_rises[0], 16);
    chk("busy_dones",  m_dones, 1);

    // Reset mid-frame after the 5th SCLK rise of an all-ones frame.
    begin
      int   rises;
      logic p;
      bit   saw_done;
      rises = 0; p = 1'b0; saw_done = 1'b0;
      @(negedge clk);
      bus0.tx_valid = 1'b1;
      bus0.tx_data  = 16'hFFFF;
      @(negedge clk);
      bus0.tx_valid = 1'b0;
      for (int c = 0; c < 200 && rises < 5; c++) begin
        if (!p && sclk0) rises++;
        p = sclk0;
        if (rises < 5) @(negedge clk);
      end
      chk("abort_reached_5th_rise", rises, 5);
      chk("abort_mosi_before", int'(mosi0), 1);
      #2 reset_b = 1'b0;
      #1;
      chk("abort_cs",   int'(cs0), 1);
      chk("abort_sclk", int'(sclk0), 0);
      chk("abort_mosi", int'(mosi0), 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus0.tx_done) saw_done = 1'b1;
      end
      reset_b = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus0.tx_done) saw_done = 1'b1;
      end
      chk("abort_no_done", int'(saw_done), 0);
      chk("abort_ready",   int'(bus0.tx_ready), 1);
      run_vec(16'h8001, 16'h8001);
    end

    // Minimum divider instance: WIDTH=2, CLK_DIV=1.
    begin
      int          low, rises, r1, r2, dones;
      logic        p;
      logic [1:0]  bits;
      low = 0; rises = 0; r1 = 0; r2 = 0; dones = 0; p = 1'b0; bits = '0;
      @(negedge clk);
      bus1.tx_valid = 1'b1;
      bus1.tx_data  = 2'b10;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c == 0) begin
          bus1.tx_valid = 1'b0;
          bus1.tx_data  = 2'b01;
        end
        if (!cs1) low++;
        if (!p && sclk1) begin
          rises++;
          bits = {bits[0], mosi1};
          if (rises == 1) r1 = c;
          if (rises == 2) r2 = c;
        end
        if (bus1.tx_done) dones++;
        p = sclk1;
      end
      chk("min_cs_low", low, 5);
      chk("min_rises",  rises, 2);
      chk("min_period", r2 - r1, 2);
`ifdef SPI_TX_LSB_FIRST_EN
      chk("min_bits",   int'(bits), 1);
`else
      chk("min_bits",   int'(bits), 2);
`endif
      chk("min_dones",  dones, 1);
      chk("min_mosi_idle", int'(mosi1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
